// File: rtl/bridge_utils.sv
// Shared types and constants for the AXI2APB bridge scheduler.
// No logic, so no latency; backpressure is handled by the modules that import it.
package bridge_utils;

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        SETUP,
        ACCESS,
        RD_PUSH,
        WR_RESP
    } engine_state_t;

    typedef enum logic {
        GNT_RD,
        GNT_WR
    } grant_t;

    localparam int BEAT_CNT_W = 8;

    // Byte stride between consecutive beats of an incrementing burst.
    function automatic int addr_inc(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bridge_rr_arbiter.sv
// Two-requester round-robin arbiter; the grant is combinational and the pointer updates on an enabled grant.
// Zero latency; requesters hold their request until they see their ack.
module bridge_rr_arbiter
    import bridge_utils::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   rd_req,
    input  logic   wr_req,
    output logic   gnt_vld,
    output grant_t gnt
);

    grant_t last_gnt;

    always_comb begin
        gnt = GNT_RD;
        if (rd_req && wr_req) begin
            gnt = (last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
        end else if (wr_req) begin
            gnt = GNT_WR;
        end
    end

    assign gnt_vld = en && (rd_req || wr_req);

    // Resetting to "write was last" makes read win the first contested grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= GNT_WR;
        end else if (gnt_vld) begin
            last_gnt <= gnt;
        end
    end

endmodule

// File: rtl/bridge_engine.sv
// AXI2APB scheduler: grants read/write bursts round-robin and runs each beat over one APB master.
// Zero-wait slave: 3 cycles per beat plus 1 grant cycle per burst; stalls on rd_beat_ready, wr_data_valid, wr_resp_ready, pready.
module bridge_engine
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_len,
    output logic                  rd_ack,
    output logic                  rd_beat_valid,
    output logic [DATA_WIDTH-1:0] rd_beat_data,
    output logic                  rd_beat_err,
    output logic                  rd_beat_last,
    input  logic                  rd_beat_ready,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_len,
    output logic                  wr_ack,
    input  logic                  wr_data_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_data_ready,
    output logic                  wr_resp_valid,
    output logic                  wr_resp_err,
    input  logic                  wr_resp_ready,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(addr_inc(DATA_WIDTH));
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    engine_state_t         state_q, state_d;
    grant_t                gnt_q, gnt;
    logic                  gnt_vld, arb_en;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BEAT_CNT_W-1:0] len_q, beat_cnt;
    logic [31:0]           tmo_cnt;
    logic [DATA_WIDTH-1:0] pwdata_q, rdata_q;
    logic                  rerr_q, err_acc;
    logic                  last_beat, tmo_hit, access_done, beat_err, adv;

    bridge_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    assign last_beat   = (beat_cnt == len_q);
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST) && !pready;
    assign access_done = (state_q == ACCESS) && (pready || tmo_hit);
    // A timed-out beat is reported as an error regardless of pslverr.
    assign beat_err    = pready ? pslverr : 1'b1;

    always_comb begin
        state_d       = state_q;
        arb_en        = (state_q == IDLE);
        rd_ack        = 1'b0;
        wr_ack        = 1'b0;
        wr_data_ready = 1'b0;
        adv           = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    if (gnt == GNT_RD) begin
                        rd_ack  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        wr_ack  = 1'b1;
                        state_d = WR_FETCH;
                    end
                end
            end
            WR_FETCH: begin
                if (wr_data_valid) begin
                    wr_data_ready = 1'b1;
                    state_d       = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (access_done) begin
                    if (gnt_q == GNT_RD) begin
                        state_d = RD_PUSH;
                    end else if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        adv     = 1'b1;
                        state_d = WR_FETCH;
                    end
                end
            end
            RD_PUSH: begin
                if (rd_beat_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        adv     = 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            WR_RESP: begin
                if (wr_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q    <= GNT_RD;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            err_acc  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        gnt_q    <= gnt;
                        addr_q   <= (gnt == GNT_RD) ? rd_addr : wr_addr;
                        len_q    <= (gnt == GNT_RD) ? rd_len : wr_len;
                        beat_cnt <= '0;
                        err_acc  <= 1'b0;
                    end
                end
                WR_FETCH: begin
                    if (wr_data_valid) pwdata_q <= wr_data;
                end
                ACCESS: begin
                    if (access_done) begin
                        tmo_cnt <= '0;
                        rdata_q <= pready ? prdata : '0;
                        rerr_q  <= beat_err;
                        if (gnt_q == GNT_WR) err_acc <= err_acc | beat_err;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                WR_RESP: begin
                    if (wr_resp_ready) err_acc <= 1'b0;
                end
                default: ;
            endcase
            if (adv) begin
                addr_q   <= addr_q + ADDR_STEP;
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign psel          = (state_q == SETUP) || (state_q == ACCESS);
    assign penable       = (state_q == ACCESS);
    assign pwrite        = psel && (gnt_q == GNT_WR);
    assign paddr         = addr_q;
    assign pwdata        = pwdata_q;
    assign rd_beat_valid = (state_q == RD_PUSH);
    assign rd_beat_data  = rdata_q;
    assign rd_beat_err   = rerr_q;
    assign rd_beat_last  = rd_beat_valid && last_beat;
    assign wr_resp_valid = (state_q == WR_RESP);
    assign wr_resp_err   = err_acc;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bridge_engine.sv
// Self-checking bench for bridge_engine: burst table plus arbitration, timeout and mid-burst reset sequences.
module tb_bridge_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr;
    logic [7:0]  rd_len, wr_len;
    logic        rd_ack, wr_ack;
    logic        rd_beat_valid, rd_beat_err, rd_beat_last, rd_beat_ready;
    logic [31:0] rd_beat_data;
    logic        wr_data_valid, wr_data_ready;
    logic [31:0] wr_data;
    logic        wr_resp_valid, wr_resp_err, wr_resp_ready;
    logic        psel, penable, pwrite, pready, pslverr, busy;
    logic [31:0] paddr, pwdata, prdata;

    always #5 clk = ~clk;

    bridge_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_beat_valid(rd_beat_valid), .rd_beat_data(rd_beat_data), .rd_beat_err(rd_beat_err),
        .rd_beat_last(rd_beat_last), .rd_beat_ready(rd_beat_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_data_ready(wr_data_ready),
        .wr_resp_valid(wr_resp_valid), .wr_resp_err(wr_resp_err), .wr_resp_ready(wr_resp_ready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] wdata; } apb_t;
    typedef struct packed { logic [31:0] data; logic err; logic last; } rdb_t;
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          err_beat;
        bit          hang;
        int          stall;
        logic [31:0] key;
        bit          exp_err;
    } vec_t;

    apb_t        apb_exp[$];
    rdb_t        rd_exp[$];
    logic        wr_exp[$];
    logic [31:0] wq[$];
    int          gnt_log[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          setup_cnt = 0;
    int          access_cycles = 0;
    int          acc_base = 0;
    int          err_beat = -1;
    int          stall_left = 0;
    bit          hang = 1'b0;
    logic [31:0] rd_key = '0;

    // APB slave: zero wait states unless hung; read data is a keyed function of the address.
    assign pready  = psel && penable && !hang;
    assign prdata  = paddr ^ rd_key;
    assign pslverr = psel && penable && (err_beat >= 0) && ((setup_cnt - acc_base - 1) == err_beat);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write FIFO model and read-beat consumer: decide on the falling edge, update just after the rising edge.
    always begin
        bit take, v;
        @(negedge clk);
        take = wr_data_ready && wr_data_valid;
        v    = rd_beat_valid;
        @(posedge clk);
        #1;
        if (take && wq.size() != 0) void'(wq.pop_front());
        wr_data_valid = (wq.size() != 0);
        wr_data       = (wq.size() != 0) ? wq[0] : 32'h0;
        if (v && stall_left > 0) stall_left--;
        rd_beat_ready = (stall_left == 0);
    end

    bit   rd_stalled = 1'b0;
    rdb_t held;

    always @(negedge clk) begin
        apb_t e;
        rdb_t r;
        logic w;
        if (rst_n) begin
            if (penable) check("penable_needs_psel", psel, 1);
            if (psel && !penable) begin
                setup_cnt++;
                check("apb_expected", apb_exp.size() != 0, 1);
                if (apb_exp.size() != 0) begin
                    e = apb_exp.pop_front();
                    check("paddr", paddr, e.addr);
                    check("pwrite", pwrite, e.wr);
                    if (e.wr) check("pwdata", pwdata, e.wdata);
                end
            end
            if (psel && penable) access_cycles++;
            if (rd_beat_valid) begin
                check("psel_idle_during_push", psel, 0);
                if (rd_stalled) check("rd_hold_stable", {rd_beat_data, rd_beat_err, rd_beat_last}, held);
                if (rd_beat_ready) begin
                    check("rd_expected", rd_exp.size() != 0, 1);
                    if (rd_exp.size() != 0) begin
                        r = rd_exp.pop_front();
                        check("rd_beat_data", rd_beat_data, r.data);
                        check("rd_beat_err", rd_beat_err, r.err);
                        check("rd_beat_last", rd_beat_last, r.last);
                    end
                end
            end
            rd_stalled = rd_beat_valid && !rd_beat_ready;
            held       = '{rd_beat_data, rd_beat_err, rd_beat_last};
            if (wr_resp_valid && wr_resp_ready) begin
                check("wr_resp_expected", wr_exp.size() != 0, 1);
                if (wr_exp.size() != 0) begin
                    w = wr_exp.pop_front();
                    check("wr_resp_err", wr_resp_err, w);
                end
            end
            if (rd_ack) gnt_log.push_back(0);
            if (wr_ack) gnt_log.push_back(1);
        end else begin
            rd_stalled = 1'b0;
        end
    end

    task automatic do_reset();
        rd_req = 1'b0;
        wr_req = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {rd_ack, wr_ack, rd_beat_valid, rd_beat_err, rd_beat_last, wr_data_ready,
                           wr_resp_valid, wr_resp_err, psel, penable, pwrite, busy}, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rd_data", rd_beat_data, 0);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (apb_exp.size() == 0) && (rd_exp.size() == 0) && (wr_exp.size() == 0) && !busy;
        end
        check(name, ok, 1);
    endtask

    task automatic run_vec(input vec_t v, input bit wait_done);
        logic [31:0] a;
        bit          seen;
        acc_base   = setup_cnt;
        hang       = v.hang;
        err_beat   = v.err_beat;
        rd_key     = v.key;
        stall_left = v.stall;
        a = v.addr;
        for (int i = 0; i <= v.len; i++) begin
            apb_exp.push_back(apb_t'{addr: a, wr: v.wr, wdata: v.wr ? 32'(i + 1) : 32'h0});
            if (v.wr) wq.push_back(32'(i + 1));
            else rd_exp.push_back(rdb_t'{data: v.hang ? 32'h0 : (a ^ v.key),
                                         err: v.hang || (i == v.err_beat), last: (i == v.len)});
            a = a + 32'd4;
        end
        if (v.wr) wr_exp.push_back(v.exp_err);
        @(posedge clk);
        #1;
        if (v.wr) begin
            wr_req = 1'b1; wr_addr = v.addr; wr_len = 8'(v.len);
        end else begin
            rd_req = 1'b1; rd_addr = v.addr; rd_len = 8'(v.len);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = v.wr ? wr_ack : rd_ack;
        end
        check("grant_ack", seen, 1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", rd_ack | wr_ack, 0);
        if (wait_done) wait_idle("burst_done");
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   hit;
        int   base;
        rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; rd_len = 0; wr_len = 0;
        wr_data_valid = 0; wr_data = 0; rd_beat_ready = 1; wr_resp_ready = 1;
        //           wr  addr          len  err hang stall key                        exp_err
        vecs[0] = '{0, 32'h0000_1000, 0,   -1, 0,   0,   32'h0000_1000 ^ 32'hDEADBEEF, 0};
        vecs[1] = '{1, 32'h0000_2000, 3,   1,  0,   0,   32'h0,                        1};
        vecs[2] = '{0, 32'h0000_3000, 1,   -1, 0,   5,   32'h1234_5678,                0};
        vecs[3] = '{1, 32'h0000_4000, 0,   -1, 0,   0,   32'h0,                        0};
        vecs[4] = '{0, 32'hFFFF_FFF8, 3,   -1, 0,   0,   32'h0F0F_0F0F,                0};
        vecs[5] = '{0, 32'h0000_5000, 2,   1,  0,   0,   32'hA5A5_A5A5,                0};
        vecs[6] = '{0, 32'h0000_A000, 255, -1, 0,   0,   32'h5A5A_0000,                0};

        do_reset();
        for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b1);

        // Slave never answers: four ACCESS cycles, then an errored zero beat.
        base = access_cycles;
        v = '{0, 32'h0000_6000, 0, -1, 1, 0, 32'hFFFF_FFFF, 0};
        run_vec(v, 1'b1);
        check("timeout_access_cycles", access_cycles - base, 4);
        check("timeout_idle", busy, 0);
        hang = 1'b0;

        // Reset during the ACCESS phase of the second beat of a 4-beat read.
        v = '{0, 32'h0000_7000, 3, -1, 0, 0, 32'h1111_2222, 0};
        run_vec(v, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            hit = psel && penable && ((setup_cnt - acc_base) == 2);
        end
        check("reached_beat2_access", hit, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bus_released", {psel, penable, busy}, 0);
        apb_exp.delete();
        rd_exp.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("midrst_no_output", {rd_beat_valid, wr_resp_valid, psel}, 0);
        end

        // Both requesters continuously asserted from reset: R, W, R, W.
        do_reset();
        gnt_log.delete();
        acc_base = setup_cnt; err_beat = -1; rd_key = 32'h0BAD_F00D; stall_left = 0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                apb_exp.push_back(apb_t'{addr: 32'h8000, wr: 1'b0, wdata: 32'h0});
                rd_exp.push_back(rdb_t'{data: 32'h8000 ^ 32'h0BAD_F00D, err: 1'b0, last: 1'b1});
            end else begin
                apb_exp.push_back(apb_t'{addr: 32'h9000, wr: 1'b1, wdata: 32'(256 + k)});
                wq.push_back(32'(256 + k));
                wr_exp.push_back(1'b0);
            end
        end
        @(posedge clk);
        #1;
        rd_req = 1'b1; rd_addr = 32'h8000; rd_len = 8'd0;
        wr_req = 1'b1; wr_addr = 32'h9000; wr_len = 8'd0;
        for (int c = 0; c < 100 && gnt_log.size() < 4; c++) @(negedge clk);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_idle("arb_done");
        check("arb_grant_count", gnt_log.size(), 4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) check("arb_order", gnt_log[k], k % 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_engine.md
Name: bridge_engine

Overview:
- Central scheduler of the AXI2APB bridge. Arbitrates round-robin between the buffered read-address stream and the buffered write-address stream.
- Sequences each granted burst beat by beat onto a single APB master port.
- Returns read beats to the reader's data FIFO and a single write response per burst to the writer.
- Sits between the axi_reader/axi_writer middle registers and the APB bus.

Parameters:
- ADDR_WIDTH, 32, AXI/APB address width.
- DATA_WIDTH, 32, data width; beat address increment = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for pready before a beat is aborted as error; 0 disables the timeout.

Ports:
- clk  in  1  bridge clock
- rst_n  in  1  synchronous active-low reset
- rd_req  in  1  reader holds a valid read burst descriptor
- rd_addr  in  ADDR_WIDTH  read burst start address
- rd_len  in  8  read beats minus 1
- rd_ack  out  1  one-cycle pulse: descriptor consumed
- rd_beat_valid  out  1  read beat available
- rd_beat_data  out  DATA_WIDTH  prdata of beat
- rd_beat_err  out  1  beat got pslverr or timeout
- rd_beat_last  out  1  final beat of burst
- rd_beat_ready  in  1  reader FIFO accepts beat
- wr_req  in  1  writer holds a valid write burst descriptor
- wr_addr  in  ADDR_WIDTH  write burst start address
- wr_len  in  8  write beats minus 1
- wr_ack  out  1  one-cycle pulse: descriptor consumed
- wr_data_valid  in  1  write FIFO non-empty
- wr_data  in  DATA_WIDTH  write FIFO head
- wr_data_ready  out  1  pop write FIFO
- wr_resp_valid  out  1  burst response valid
- wr_resp_err  out  1  1 = SLVERR (any beat failed)
- wr_resp_ready  in  1  writer accepted response
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready, pslverr  in  1 each  APB completion and error
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, all outputs 0, round-robin pointer favours read, beat and timeout counters 0.
  - Reset mid-burst drops the burst; no response is issued.
- IDLE: if exactly one requester is asserting, grant it. If both, grant the one not granted last.
  - Grant cycle: pulse rd_ack/wr_ack, latch addr/len, toggle pointer. Next state SETUP (read) or WR_FETCH (write).
- WR_FETCH: wait for wr_data_valid. Then pulse wr_data_ready for one cycle, latch wr_data into pwdata, go to SETUP.
- SETUP: psel=1, penable=0, paddr = current address, pwrite = grant is write. Always exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1.
  - On pready: capture prdata/pslverr, deassert psel/penable next cycle.
  - Read grant: go to RD_PUSH.
  - Write grant: OR pslverr into the error accumulator, then go to the write next-beat step.
  - Timeout counter increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES with no pready, the beat completes with err=1 and data 0, and the bus is released.
- RD_PUSH: hold rd_beat_valid with data/err/last stable until rd_beat_ready. rd_beat_last = (beat count == latched len).
- Next-beat step:
  - Beat count == len: a read returns to IDLE; a write goes to WR_RESP.
  - Otherwise: address += DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wraps, no 4 KB check), beat count +1. A read goes to SETUP; a write goes to WR_FETCH.
- WR_RESP: hold wr_resp_valid and wr_resp_err until wr_resp_ready, then clear the accumulator and go to IDLE.
- Latency:
  - Zero-wait-state slave, ready consumers: read beat = 3 cycles (SETUP, ACCESS, RD_PUSH); write beat = 3 cycles (WR_FETCH, SETUP, ACCESS).
  - Grant adds 1 IDLE cycle per burst.
- Requests are sampled only in IDLE. A new request arriving mid-burst waits; no preemption.
- rd_len/wr_len = 0 means a single beat; 255 means 256 beats. The beat counter is 8 bits and never wraps within a burst.
- psel is never asserted without a granted burst. penable is never 1 unless psel is 1.

Decomposition:
- Package bridge_utils holds:
  - engine_state_t enum: IDLE, WR_FETCH, SETUP, ACCESS, RD_PUSH, WR_RESP.
  - grant_t enum: GNT_RD, GNT_WR.
  - BEAT_CNT_W = 8.
  - Localparam ADDR_INC function of DATA_WIDTH.
- One sub-module, bridge_rr_arbiter: 2-requester round-robin with an enable input, a grant output and a last-grant pointer register.

Test Plan:
- Single read, rd_addr=0x1000, rd_len=0, zero-wait slave returns 0xDEADBEEF -> one APB read at paddr 0x1000; rd_beat_data=0xDEADBEEF, last=1, err=0; rd_ack pulse.
- Write burst, wr_addr=0x2000, wr_len=3, data 1..4; slave gives pslverr on beat 2 -> paddr 0x2000/04/08/0C, pwdata 1..4; single wr_resp with err=1.
- rd_req and wr_req both asserted continuously, len=0 -> grants alternate R,W,R,W; first grant is read after reset.
- Read, len=1; rd_beat_ready held low 5 cycles on beat 0 -> data held stable; no SETUP for beat 1 until accepted.
- Slave never asserts pready, TIMEOUT_CYCLES=4 -> ACCESS lasts 4 cycles; beat returned with err=1, data 0; engine returns to IDLE.
- rst_n driven low during ACCESS of beat 2 of 4 -> next cycle psel/penable=0, state IDLE, no rd_beat/wr_resp emitted.
